// File: rtl/player_turn_ctrl.sv
// player_turn_ctrl: per-player frame physics plus the turn sequencer
// (move/aim, fire, wait for the bomb, hand over to the next player).
`default_nettype none

module player_turn_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int V_MAX       = 10,
  parameter int GRAV_DIV    = 6,
  parameter int MOVE_DIV    = 6,
  parameter int JUMP_DIV    = 32,
  parameter int AIM_DIV     = 16,
  parameter int TURN_FRAMES = 600,
  parameter int ANGLE_MAX   = 8,
  parameter int POWER_MAX   = 7
) (
  input  logic                      reset,
  input  logic                      frame_clk,
  input  logic [7:0]                keycode,
  input  logic [NUM_PLAYERS-1:0]    dd,
  input  logic [NUM_PLAYERS-1:0]    uu,
  input  logic [NUM_PLAYERS-1:0]    impact,
  input  logic                      bomb_exploded,
  output logic [10*NUM_PLAYERS-1:0] x_flat,
  output logic [10*NUM_PLAYERS-1:0] y_flat,
  output logic [9:0]                size,
  output logic [1:0]                active,
  output logic [3:0]                angle,
  output logic [2:0]                power,
  output logic                      launch,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    S_MOVE  = 2'd0,
    S_FIRED = 2'd1,
    S_WAIT  = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  localparam logic [7:0]         GRAV_LIM = 8'(GRAV_DIV);
  localparam logic [7:0]         MOVE_LIM = 8'(MOVE_DIV);
  localparam logic [7:0]         JUMP_LIM = 8'(JUMP_DIV);
  localparam logic [7:0]         AIM_LIM  = 8'(AIM_DIV);
  localparam logic [9:0]         TURN_LIM = 10'(TURN_FRAMES - 1);
  localparam logic [3:0]         ANG_LIM  = 4'(ANGLE_MAX);
  localparam logic [2:0]         POW_LIM  = 3'(POWER_MAX);
  localparam logic [1:0]         LAST     = 2'(NUM_PLAYERS - 1);
  localparam logic signed [11:0] VLIM     = 12'(V_MAX);

  localparam logic [7:0] KEY_A = 8'h04, KEY_D = 8'h07, KEY_W = 8'h1A, KEY_Q = 8'h14;
  localparam logic [7:0] KEY_E = 8'h08, KEY_1 = 8'h1E, KEY_3 = 8'h20, KEY_S = 8'h16;

  state_t      state_q, state_d;
  logic [1:0]  active_q, active_d;
  logic [3:0]  angle_q, angle_d;
  logic [2:0]  power_q, power_d;
  logic [7:0]  mcnt_q, mcnt_d, jcnt_q, jcnt_d, acnt_q, acnt_d;
  logic [9:0]  tcnt_q, tcnt_d;

  logic               keys_en, aim_rdy, jump_go, aim_chg;
  logic signed [11:0] dx_key, dy_key;

  assign keys_en = (state_q == S_MOVE);
  assign aim_rdy = (acnt_q == AIM_LIM);
  assign jump_go = keys_en && (keycode == KEY_W) && (jcnt_q == JUMP_LIM);

  // Key-driven velocity deltas, applied to the active player only
  always_comb begin
    dx_key = '0;
    if (keys_en && (mcnt_q == MOVE_LIM)) begin
      if (keycode == KEY_A)      dx_key = -12'sd1;
      else if (keycode == KEY_D) dx_key = 12'sd1;
    end
    dy_key = jump_go ? -12'sd4 : 12'sd0;
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    angle_d  = angle_q;
    power_d  = power_q;
    tcnt_d   = tcnt_q;
    aim_chg  = 1'b0;
    mcnt_d   = (mcnt_q == MOVE_LIM) ? 8'd0 : mcnt_q + 8'd1;
    jcnt_d   = (jcnt_q == JUMP_LIM) ? jcnt_q : jcnt_q + 8'd1;
    acnt_d   = (acnt_q == AIM_LIM) ? acnt_q : acnt_q + 8'd1;
    case (state_q)
      S_MOVE: begin
        if (jump_go) jcnt_d = '0;
        if (aim_rdy) begin
          if (keycode == KEY_Q && angle_q != 4'd0) begin
            angle_d = angle_q - 4'd1; aim_chg = 1'b1;
          end else if (keycode == KEY_E && angle_q != ANG_LIM) begin
            angle_d = angle_q + 4'd1; aim_chg = 1'b1;
          end else if (keycode == KEY_1 && power_q != 3'd0) begin
            power_d = power_q - 3'd1; aim_chg = 1'b1;
          end else if (keycode == KEY_3 && power_q != POW_LIM) begin
            power_d = power_q + 3'd1; aim_chg = 1'b1;
          end
        end
        if (aim_chg) acnt_d = '0;
        if (keycode == KEY_S && aim_rdy)  state_d = S_FIRED;
        else if (tcnt_q == TURN_LIM)      state_d = S_NEXT;
        else                              tcnt_d  = tcnt_q + 10'd1;
      end
      S_FIRED: state_d = S_WAIT;
      S_WAIT:  if (bomb_exploded) state_d = S_NEXT;
      S_NEXT: begin
        active_d = (active_q == LAST) ? 2'd0 : active_q + 2'd1;
        angle_d  = 4'd6;
        power_d  = 3'd4;
        tcnt_d   = '0;
        state_d  = S_MOVE;
      end
      default: state_d = S_MOVE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_MOVE;
      active_q <= '0;
      angle_q  <= 4'd6;
      power_q  <= 3'd4;
      mcnt_q   <= '0;
      jcnt_q   <= '0;
      acnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      angle_q  <= angle_d;
      power_q  <= power_d;
      mcnt_q   <= mcnt_d;
      jcnt_q   <= jcnt_d;
      acnt_q   <= acnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    localparam logic [9:0] X0 = 10'(80 + 480 * i / (NUM_PLAYERS - 1));

    logic [9:0]         x_q, x_d, y_q, y_d;
    logic signed [9:0]  vx_q, vx_d, vy_q, vy_d;
    logic [7:0]         gcnt_q, gcnt_d;
    logic signed [11:0] vx_t, vy_t;

    always_comb begin
      gcnt_d = (gcnt_q == GRAV_LIM) ? 8'd0 : gcnt_q + 8'd1;
      vx_t   = {{2{vx_q[9]}}, vx_q};
      vy_t   = {{2{vy_q[9]}}, vy_q};
      if (dd[i]) begin
        vx_t = '0;
        if (vy_t >= 0) vy_t = '0;
      end else begin
        if (gcnt_q == GRAV_LIM) vy_t = vy_t + 12'sd1;
        if (active_q == 2'(i)) begin
          vx_t = vx_t + dx_key;
          vy_t = vy_t + dy_key;
        end
        if (uu[i])     vy_t = 12'sd1;
        if (impact[i]) vx_t = '0;
      end
      if (vx_t > VLIM)       vx_t = VLIM;
      else if (vx_t < -VLIM) vx_t = -VLIM;
      if (vy_t > VLIM)       vy_t = VLIM;
      else if (vy_t < -VLIM) vy_t = -VLIM;
      // Bounce decisions use the pre-move position with the updated velocity
      if ((y_q >= 10'd470 && vy_t >= 0) || (y_q <= 10'd9 && vy_t < 0)) vy_t = -vy_t;
      if ((x_q >= 10'd630 && vx_t >= 0) || (x_q <= 10'd9 && vx_t < 0)) vx_t = -vx_t;
      vx_d = vx_t[9:0];
      vy_d = vy_t[9:0];

      if (x_q[9:8] == 2'b11) x_d = '0;
      else if (dd[i])        x_d = x_q;
      else                   x_d = x_q + vx_q;
      if (y_q[9:8] == 2'b11) y_d = '0;
      else if (dd[i])        y_d = y_q - 10'd2;
      else                   y_d = y_q + vy_q;
    end

    always_ff @(posedge frame_clk or posedge reset) begin
      if (reset) begin
        x_q    <= X0;
        y_q    <= 10'd200;
        vx_q   <= '0;
        vy_q   <= '0;
        gcnt_q <= '0;
      end else begin
        x_q    <= x_d;
        y_q    <= y_d;
        vx_q   <= vx_d;
        vy_q   <= vy_d;
        gcnt_q <= gcnt_d;
      end
    end

    assign x_flat[10*i +: 10] = x_q;
    assign y_flat[10*i +: 10] = y_q;
  end

  assign size   = 10'd4;
  assign active = active_q;
  assign angle  = angle_q;
  assign power  = power_q;
  assign launch = (state_q == S_FIRED);
  assign state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_player_turn_ctrl.sv
// tb_player_turn_ctrl: directed turn scenarios plus random play, every frame
// compared against an integer reference model of the game rules.
`default_nettype none

module tb_player_turn_ctrl;

  localparam int NP = 2, VM = 10, GD = 6, MD = 6, JD = 32, AD = 16, TF = 600, AM = 8, PM = 7;

  logic            reset, frame_clk, bomb_exploded, launch;
  logic [7:0]      keycode;
  logic [NP-1:0]   dd, uu, impact;
  logic [10*NP-1:0] x_flat, y_flat;
  logic [9:0]      size;
  logic [1:0]      active, state;
  logic [3:0]      angle;
  logic [2:0]      power;

  player_turn_ctrl #(
    .NUM_PLAYERS(NP), .V_MAX(VM), .GRAV_DIV(GD), .MOVE_DIV(MD), .JUMP_DIV(JD),
    .AIM_DIV(AD), .TURN_FRAMES(TF), .ANGLE_MAX(AM), .POWER_MAX(PM)
  ) dut (
    .reset(reset), .frame_clk(frame_clk), .keycode(keycode), .dd(dd), .uu(uu),
    .impact(impact), .bomb_exploded(bomb_exploded), .x_flat(x_flat), .y_flat(y_flat),
    .size(size), .active(active), .angle(angle), .power(power), .launch(launch),
    .state(state)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain integers, state 0..3 as numbered by the interface
  int m_x[NP], m_y[NP], m_vx[NP], m_vy[NP], m_g[NP];
  int m_state, m_active, m_angle, m_power, m_mc, m_jc, m_ac, m_tc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int start_x(input int p);
    return 80 + 480 * p / (NP - 1);
  endfunction

  function automatic int clampv(input int v);
    if (v > VM)  return VM;
    if (v < -VM) return -VM;
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_x[p] = start_x(p); m_y[p] = 200; m_vx[p] = 0; m_vy[p] = 0; m_g[p] = 0;
    end
    m_state = 0; m_active = 0; m_angle = 6; m_power = 4;
    m_mc = 0; m_jc = 0; m_ac = 0; m_tc = 0;
  endtask

  // Advance the model by one frame using the inputs currently applied
  task automatic model_step();
    int nx[NP], ny[NP], nvx[NP], nvy[NP];
    int ns, na, nang, npow, nac, njc, ntc;
    bit in_move, ready, changed;
    in_move = (m_state == 0);
    ready   = (m_ac >= AD);
    for (int p = 0; p < NP; p++) begin
      int vx, vy;
      vx = m_vx[p]; vy = m_vy[p];
      if (dd[p]) begin
        vx = 0;
        if (vy >= 0) vy = 0;
      end else begin
        if (m_g[p] == GD) vy += 1;
        if (in_move && p == m_active) begin
          if (m_mc == MD && keycode == 8'h04) vx -= 1;
          if (m_mc == MD && keycode == 8'h07) vx += 1;
          if (keycode == 8'h1A && m_jc == JD) vy -= 4;
        end
        if (uu[p])     vy = 1;
        if (impact[p]) vx = 0;
      end
      vx = clampv(vx); vy = clampv(vy);
      if ((m_y[p] >= 470 && vy >= 0) || (m_y[p] <= 9 && vy < 0)) vy = -vy;
      if ((m_x[p] >= 630 && vx >= 0) || (m_x[p] <= 9 && vx < 0)) vx = -vx;
      nvx[p] = vx; nvy[p] = vy;
      if (m_x[p] >= 768)  nx[p] = 0;
      else if (dd[p])     nx[p] = m_x[p];
      else                nx[p] = (m_x[p] + m_vx[p] + 1024) % 1024;
      if (m_y[p] >= 768)  ny[p] = 0;
      else if (dd[p])     ny[p] = (m_y[p] - 2 + 1024) % 1024;
      else                ny[p] = (m_y[p] + m_vy[p] + 1024) % 1024;
    end
    ns = m_state; na = m_active; nang = m_angle; npow = m_power; ntc = m_tc;
    njc = (m_jc >= JD) ? m_jc : m_jc + 1;
    nac = (m_ac >= AD) ? m_ac : m_ac + 1;
    case (m_state)
      0: begin
        if (keycode == 8'h1A && m_jc == JD) njc = 0;
        changed = 0;
        if (ready) begin
          case (keycode)
            8'h14: if (m_angle > 0)  begin nang = m_angle - 1; changed = 1; end
            8'h08: if (m_angle < AM) begin nang = m_angle + 1; changed = 1; end
            8'h1E: if (m_power > 0)  begin npow = m_power - 1; changed = 1; end
            8'h20: if (m_power < PM) begin npow = m_power + 1; changed = 1; end
            default: ;
          endcase
        end
        if (changed) nac = 0;
        if (keycode == 8'h16 && ready) ns = 1;
        else if (m_tc >= TF - 1)       ns = 3;
        else                           ntc = m_tc + 1;
      end
      1: ns = 2;
      2: if (bomb_exploded) ns = 3;
      default: begin
        na = (m_active + 1) % NP; nang = 6; npow = 4; ntc = 0; ns = 0;
      end
    endcase
    for (int p = 0; p < NP; p++) begin
      m_x[p] = nx[p]; m_y[p] = ny[p]; m_vx[p] = nvx[p]; m_vy[p] = nvy[p];
      m_g[p] = (m_g[p] == GD) ? 0 : m_g[p] + 1;
    end
    m_mc = (m_mc == MD) ? 0 : m_mc + 1;
    m_state = ns; m_active = na; m_angle = nang; m_power = npow;
    m_jc = njc; m_ac = nac; m_tc = ntc;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] ex, ey;
    ex = '0; ey = '0;
    for (int p = 0; p < NP; p++) begin
      ex[10*p +: 10] = 10'(m_x[p]);
      ey[10*p +: 10] = 10'(m_y[p]);
    end
    check_val({tag, "_x"},      64'(x_flat), ex);
    check_val({tag, "_y"},      64'(y_flat), ey);
    check_val({tag, "_state"},  64'(state),  64'(m_state));
    check_val({tag, "_active"}, 64'(active), 64'(m_active));
    check_val({tag, "_angle"},  64'(angle),  64'(m_angle));
    check_val({tag, "_power"},  64'(power),  64'(m_power));
    check_val({tag, "_launch"}, 64'(launch), 64'(m_state == 1));
  endtask

  task automatic check_reset_consts(input string tag);
    logic [63:0] ex, ey;
    ex = '0; ey = '0;
    for (int p = 0; p < NP; p++) begin
      ex[10*p +: 10] = 10'(start_x(p));
      ey[10*p +: 10] = 10'd200;
    end
    check_val({tag, "_state"},  64'(state),  64'd0);
    check_val({tag, "_active"}, 64'(active), 64'd0);
    check_val({tag, "_angle"},  64'(angle),  64'd6);
    check_val({tag, "_power"},  64'(power),  64'd4);
    check_val({tag, "_launch"}, 64'(launch), 64'd0);
    check_val({tag, "_x"},      64'(x_flat), ex);
    check_val({tag, "_y"},      64'(y_flat), ey);
    check_val({tag, "_size"},   64'(size),   64'd4);
  endtask

  task automatic frame(input string tag);
    model_step();
    @(posedge frame_clk);
    #1;
    check_model(tag);
  endtask

  // Reset asserted between clock edges; its effect must be visible before the next edge
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_consts(tag);
    @(posedge frame_clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] keys [9];
    logic [9:0] prev, d;
    keys = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h14, 8'h08, 8'h1E, 8'h20, 8'h16};
    reset = 1'b1; keycode = '0; dd = '0; uu = '0; impact = '0; bomb_exploded = 1'b0;
    model_reset();
    @(posedge frame_clk);
    #1;
    check_reset_consts("reset");
    reset = 1'b0;

    // Gravity from rest
    repeat (8) frame("idle");
    check_val("y0_rise", 64'(y_flat[9:0] > 10'd200), 64'd1);

    // D held while grounded, then released
    keycode = 8'h07; dd = 2'b01;
    prev = x_flat[9:0];
    repeat (30) frame("dd_hold");
    check_val("dd_hold_x0", 64'(x_flat[9:0]), 64'(prev));
    dd = '0;
    repeat (76) frame("d_ramp");
    prev = x_flat[9:0];
    frame("d_sat");
    d = x_flat[9:0] - prev;
    check_val("vx0_at_vmax", 64'(d), 64'd10);
    repeat (10) frame("d_sat");
    prev = x_flat[9:0];
    frame("d_sat");
    d = x_flat[9:0] - prev;
    check_val("vx0_saturated", 64'(d), 64'd10);
    keycode = '0;
    async_reset("rst_move");

    // Aim: E pushes angle to its ceiling
    keycode = 8'h08;
    repeat (AD + 24) frame("aim_e");
    check_val("angle_ceiling", 64'(angle), 64'(AM));

    // Fire, wait, bomb, hand-over
    for (int k = 0; k < 40 && state != 2'd1; k++) begin
      keycode = 8'h16;
      frame("fire_wait");
    end
    check_val("fired_state", 64'(state), 64'd1);
    check_val("fired_launch", 64'(launch), 64'd1);
    keycode = '0;
    frame("fired");
    check_val("wait_state", 64'(state), 64'd2);
    check_val("wait_launch", 64'(launch), 64'd0);
    bomb_exploded = 1'b1;
    frame("bomb");
    check_val("next_state", 64'(state), 64'd3);
    bomb_exploded = 1'b0;
    frame("handover");
    check_val("handover_state", 64'(state), 64'd0);
    check_val("handover_active", 64'(active), 64'd1);
    check_val("handover_angle", 64'(angle), 64'd6);
    check_val("handover_power", 64'(power), 64'd4);

    // Turn timeout with player 1 active
    repeat (TF) frame("timeout");
    check_val("timeout_state", 64'(state), 64'd3);
    frame("timeout_next");
    check_val("timeout_wrap_active", 64'(active), 64'd0);
    check_val("timeout_wrap_state", 64'(state), 64'd0);

    // Random play
    for (int k = 0; k < 2000; k++) begin
      keycode       = keys[$urandom_range(0, 8)];
      dd            = '0;
      uu            = '0;
      impact        = '0;
      for (int p = 0; p < NP; p++) begin
        dd[p]     = ($urandom_range(0, 9) == 0);
        uu[p]     = ($urandom_range(0, 11) == 0);
        impact[p] = ($urandom_range(0, 11) == 0);
      end
      bomb_exploded = ($urandom_range(0, 7) == 0);
      frame("rand");
    end

    // Reset in WAIT abandons the turn
    dd = '0; uu = '0; impact = '0; bomb_exploded = 1'b0;
    for (int k = 0; k < 100 && state != 2'd2; k++) begin
      keycode = 8'h16;
      frame("to_wait");
    end
    check_val("reach_wait", 64'(state), 64'd2);
    keycode = '0;
    async_reset("rst_wait");
    repeat (10) frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
